// File: rtl/servo_pkg.sv
// Shared types for the servo ramp blocks: duty width, duty type, ramp FSM states
// and a clamp helper.
package servo_pkg;

   localparam int unsigned DUTY_W = 8;

   typedef logic [DUTY_W-1:0] duty_t;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      LOCK
   } ramp_state_t;

   function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
      duty_t r;
      r = v;
      if (r < lo) r = lo;
      if (r > hi) r = hi;
      return r;
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector with hold enable. History resets to 1 so a
// level that is already high after reset does not produce a spurious edge.
module edge_rise (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic d,
   output logic pulse
);

   logic hist_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 1'b1;
         pulse  <= 1'b0;
      end else if (en) begin
         hist_q <= d;
         pulse  <= d & ~hist_q;
      end else begin
         pulse  <= 1'b0;
      end
   end

endmodule

// File: rtl/servo_ramp.sv
// Slews the PDM duty toward the commanded target by STEP once every FRAME_DIV
// frames. Define SERVO_CLAMP_EN to clamp accepted targets to [DUTY_MIN, DUTY_MAX].
module servo_ramp
   import servo_pkg::*;
#(
   parameter int unsigned STEP      = 4,
   parameter int unsigned FRAME_DIV = 1,
   parameter int unsigned DUTY_INIT = 128,
   parameter int unsigned DUTY_MIN  = 0,
   parameter int unsigned DUTY_MAX  = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              tgt_valid,
   output logic              tgt_ready,
   input  logic [DUTY_W-1:0] tgt_duty,
   input  logic              frame_sync,
   output logic [DUTY_W-1:0] duty,
   output logic              busy,
   output logic              at_target
);

   localparam duty_t      STEP_D   = duty_t'(STEP);
   localparam duty_t      INIT_D   = duty_t'(DUTY_INIT);
   localparam logic [7:0] CNT_LAST = 8'(FRAME_DIV - 1);

   ramp_state_t state_q;
   duty_t       duty_q;
   duty_t       target_q;
   logic [7:0]  cnt_q;
   logic        frame_tick;

   edge_rise u_edge (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .d     (frame_sync),
      .pulse (frame_tick)
   );

   logic  accept;
   duty_t tgt_in;

   assign tgt_ready = en & ~rst & (state_q != LOCK);
   assign accept    = tgt_valid & tgt_ready;

`ifdef SERVO_CLAMP_EN
   localparam duty_t MIN_D = duty_t'(DUTY_MIN);
   localparam duty_t MAX_D = duty_t'(DUTY_MAX);

   if (DUTY_INIT < DUTY_MIN || DUTY_INIT > DUTY_MAX) begin : g_bad_init
      $error("servo_ramp: DUTY_INIT outside [DUTY_MIN, DUTY_MAX]");
   end

   assign tgt_in = clamp_duty(tgt_duty, MIN_D, MAX_D);
`else
   assign tgt_in = tgt_duty;
`endif

   // Step arithmetic in 9-bit signed so the approach never overshoots or wraps.
   logic signed [DUTY_W:0] diff;
   logic        [DUTY_W:0] mag;
   logic                   go_up;
   logic                   arrive;
   logic                   last_frame;
   logic                   step;
   duty_t                  stepped;
   duty_t                  duty_nx;
   duty_t                  target_nx;

   assign diff       = $signed({1'b0, target_q}) - $signed({1'b0, duty_q});
   assign go_up      = ~diff[DUTY_W];
   assign mag        = go_up ? $unsigned(diff) : $unsigned(-diff);
   assign arrive     = (mag <= {1'b0, STEP_D});
   assign last_frame = (cnt_q == CNT_LAST);
   assign step       = frame_tick & (state_q == RAMP) & last_frame;

   always_comb begin
      stepped = target_q;
      if (!arrive) begin
         stepped = go_up ? (duty_q + STEP_D) : (duty_q - STEP_D);
      end
   end

   // A target accepted on a step edge loads alongside the step; the step uses the old one.
   assign duty_nx   = step ? stepped : duty_q;
   assign target_nx = accept ? tgt_in : target_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         duty_q   <= INIT_D;
         target_q <= INIT_D;
         cnt_q    <= 8'd0;
         busy     <= 1'b0;
      end else if (en) begin
         duty_q   <= duty_nx;
         target_q <= target_nx;
         if (frame_tick && state_q == RAMP) begin
            cnt_q <= last_frame ? 8'd0 : cnt_q + 8'd1;
         end
         case (state_q)
            RAMP: begin
               if ((step && arrive) || duty_nx == target_nx) begin
                  state_q <= LOCK;
                  busy    <= 1'b0;
               end
            end
            IDLE, LOCK: begin
               if (duty_nx != target_nx) begin
                  state_q <= RAMP;
                  busy    <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy    <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

   assign duty      = duty_q;
   assign at_target = en & (state_q == LOCK);

endmodule

// File: tb/tb_servo_ramp.sv
// Randomized bench for servo_ramp: two instances (default and slow/clamped) driven
// by shared stimulus and compared every cycle against a behavioural model.
module tb_servo_ramp;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       tgt_valid = 1'b0;
   logic [7:0] tgt_duty = 8'd0;
   logic       frame_sync = 1'b0;

   logic [7:0] duty_w [2];
   logic       busy_w [2];
   logic       ready_w [2];
   logic       at_w [2];

   always #5 clk = ~clk;

   servo_ramp u_dut_a (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .tgt_valid  (tgt_valid),
      .tgt_ready  (ready_w[0]),
      .tgt_duty   (tgt_duty),
      .frame_sync (frame_sync),
      .duty       (duty_w[0]),
      .busy       (busy_w[0]),
      .at_target  (at_w[0])
   );

   servo_ramp #(
      .STEP      (7),
      .FRAME_DIV (3),
      .DUTY_INIT (100),
      .DUTY_MIN  (20),
      .DUTY_MAX  (230)
   ) u_dut_b (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .tgt_valid  (tgt_valid),
      .tgt_ready  (ready_w[1]),
      .tgt_duty   (tgt_duty),
      .frame_sync (frame_sync),
      .duty       (duty_w[1]),
      .busy       (busy_w[1]),
      .at_target  (at_w[1])
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model: position, goal, frame count, and whether the servo is
   // moving (mode 1) or has just arrived (mode 2).
   int p_step [2] = '{4, 7};
   int p_div  [2] = '{1, 3};
   int p_init [2] = '{128, 100};
   int p_lo   [2] = '{0, 20};
   int p_hi   [2] = '{255, 230};

   int m_duty [2];
   int m_tgt  [2];
   int m_cnt  [2];
   int m_mode [2];
   int m_hist [2];
   int m_tick [2];
   bit mvalid = 1'b0;

   function automatic int exp_ready(int i, bit r, bit e);
      return (e && !r && m_mode[i] != 2) ? 1 : 0;
   endfunction

   task automatic model_update(input int i, input bit r, input bit e, input bit v,
                               input int d, input bit fs);
      int  nt;
      int  od;
      int  ot;
      int  nd;
      bit  acc;
      bit  stp;
      bit  arrived;
      if (r) begin
         m_duty[i] = p_init[i];
         m_tgt[i]  = p_init[i];
         m_cnt[i]  = 0;
         m_mode[i] = 0;
         m_hist[i] = 1;
         m_tick[i] = 0;
      end else if (e) begin
         acc = v && (exp_ready(i, r, e) == 1);
         nt  = d;
`ifdef SERVO_CLAMP_EN
         if (nt < p_lo[i]) nt = p_lo[i];
         if (nt > p_hi[i]) nt = p_hi[i];
`endif
         od      = m_duty[i];
         ot      = m_tgt[i];
         nd      = od;
         arrived = 1'b0;
         stp     = (m_tick[i] == 1) && (m_mode[i] == 1) && (m_cnt[i] == p_div[i] - 1);
         if (m_tick[i] == 1 && m_mode[i] == 1) m_cnt[i] = stp ? 0 : m_cnt[i] + 1;
         if (stp) begin
            if (ot - od > p_step[i])      nd = od + p_step[i];
            else if (od - ot > p_step[i]) nd = od - p_step[i];
            else begin
               nd      = ot;
               arrived = 1'b1;
            end
         end
         m_duty[i] = nd;
         m_tgt[i]  = acc ? nt : ot;
         if (m_mode[i] == 1) m_mode[i] = (arrived || nd == m_tgt[i]) ? 2 : 1;
         else                m_mode[i] = (nd != m_tgt[i]) ? 1 : 0;
         m_tick[i] = (fs && m_hist[i] == 0) ? 1 : 0;
         m_hist[i] = fs ? 1 : 0;
      end else begin
         m_tick[i] = 0;
      end
   endtask

   int fphase = 0;
   int seen[$];
   int prev_a = 0;
   int pulses_a = 0;

   task automatic run_cycle(input bit r, input bit e, input bit v, input int d);
      bit fs;
      @(negedge clk);
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("duty%0d", i), int'(duty_w[i]), m_duty[i]);
            check($sformatf("busy%0d", i), int'(busy_w[i]), (m_mode[i] == 1) ? 1 : 0);
         end
         if (int'(duty_w[0]) != prev_a) begin
            seen.push_back(int'(duty_w[0]));
            prev_a = int'(duty_w[0]);
         end
      end
      fs         = (fphase < 3);
      fphase     = (fphase + 1) % 8;
      rst        = r;
      en         = e;
      tgt_valid  = v;
      tgt_duty   = 8'(d);
      frame_sync = fs;
      #1;
      if (mvalid) begin
         for (int i = 0; i < 2; i++) begin
            check($sformatf("ready%0d", i), int'(ready_w[i]), exp_ready(i, r, e));
            check($sformatf("at_target%0d", i), int'(at_w[i]),
                  (e && m_mode[i] == 2) ? 1 : 0);
         end
         if (at_w[0]) pulses_a++;
      end
      for (int i = 0; i < 2; i++) model_update(i, r, e, v, d, fs);
      if (r) mvalid = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) run_cycle(1'b0, 1'b1, 1'b0, 0);
   endtask

   task automatic issue(input int d);
      run_cycle(1'b0, 1'b1, 1'b1, d);
   endtask

   int exp_b_final;

   initial begin
      run_cycle(1'b1, 1'b0, 1'b0, 0);
      run_cycle(1'b1, 1'b1, 1'b0, 0);
      prev_a = 128;

      // Idle for ten frames: duty stays centred, nothing pulses.
      pulses_a = 0;
      idle(80);
      check("idle_duty", int'(duty_w[0]), 128);
      check("idle_pulses", pulses_a, 0);

      // 128 -> 140 in three steps, one arrival pulse.
      seen.delete();
      pulses_a = 0;
      issue(140);
      idle(40);
      check("up_steps", seen.size(), 3);
      if (seen.size() == 3) begin
         check("up_s0", seen[0], 132);
         check("up_s1", seen[1], 136);
         check("up_s2", seen[2], 140);
      end
      check("up_pulses", pulses_a, 1);
      check("up_busy", int'(busy_w[0]), 0);

      // Near-zero and near-full approaches must land exactly, not wrap.
      issue(5);
      idle(300);
      seen.delete();
      issue(2);
      idle(16);
      check("low_steps", seen.size(), 1);
      if (seen.size() == 1) check("low_val", seen[0], 2);
      issue(252);
      idle(540);
      seen.delete();
      issue(254);
      idle(16);
      check("high_steps", seen.size(), 1);
      if (seen.size() == 1) check("high_val", seen[0], 254);

      // Retarget after two steps up: reverses from 136 to 132.
      issue(128);
      idle(300);
      seen.delete();
      issue(200);
      for (int k = 0; k < 40 && seen.size() < 2; k++) idle(1);
      check("retgt_two", seen.size(), 2);
      issue(100);
      idle(10);
      check("retgt_steps", seen.size(), 3);
      if (seen.size() == 3) check("retgt_rev", seen[2], 132);

      // Long ramp with an enable gap; the clamped instance stops at its bound.
      issue(250);
      idle(60);
      for (int k = 0; k < 16; k++) run_cycle(1'b0, 1'b0, 1'b0, 0);
      idle(700);
      exp_b_final = 250;
`ifdef SERVO_CLAMP_EN
      exp_b_final = 230;
`endif
      check("final_a", int'(duty_w[0]), 250);
      check("final_b", int'(duty_w[1]), exp_b_final);

      // Random traffic: sparse targets biased toward the range ends, enable gaps,
      // occasional reset.
      for (int k = 0; k < 3000; k++) begin
         bit r;
         bit e;
         bit v;
         int d;
         r = ($urandom % 400) == 0;
         e = ($urandom % 12) != 0;
         v = ($urandom % 10) == 0;
         case ($urandom % 4)
            0:       d = $urandom_range(0, 8);
            1:       d = $urandom_range(247, 255);
            default: d = $urandom_range(0, 255);
         endcase
         run_cycle(r, e, v, d);
      end
      idle(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
